// File: rtl/gray_sync_decoder.sv
// gray_sync_decoder
// Resynchronises a Gray-coded count into the local clock domain and converts
// it back to binary. Each tracked sample is classified as hold, step up,
// step down or illegal jump. A saturating counter records the illegal jumps.
module gray_sync_decoder #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int ERR_CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     gray_in,
  input  logic                 enable,
  input  logic                 clr_err,
  output logic [WIDTH-1:0]     binary_out,
  output logic                 valid,
  output logic                 step_up,
  output logic                 step_down,
  output logic                 hold,
  output logic                 step_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    TRACK = 2'd2
  } state_t;

  state_t state, state_n;

  logic [WIDTH-1:0]     sync_q [SYNC_STAGES];
  logic [WIDTH-1:0]     g_s;
  logic [WIDTH-1:0]     g_prev, g_prev_n;
  logic [WIDTH-1:0]     bin_s, bin_prev, delta;
  logic [WIDTH-1:0]     binary_n;
  logic                 valid_n;
  logic                 hold_n, step_up_n, step_down_n, step_err_n;
  logic [ERR_CNT_W-1:0] err_count_n;

  // Standard prefix-XOR Gray-to-binary conversion, MSB first.
  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int unsigned i = 1; i < WIDTH; i++) begin
      b[WIDTH-1-i] = b[WIDTH-i] ^ g[WIDTH-1-i];
    end
    return b;
  endfunction

  // Synchroniser chain: runs every cycle, independent of enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= gray_in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign g_s      = sync_q[SYNC_STAGES-1];
  assign bin_s    = gray2bin(g_s);
  assign bin_prev = gray2bin(g_prev);
  assign delta    = bin_s - bin_prev;

  // State, tracking and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      g_prev     <= '0;
      binary_out <= '0;
      valid      <= 1'b0;
      hold       <= 1'b0;
      step_up    <= 1'b0;
      step_down  <= 1'b0;
      step_err   <= 1'b0;
      err_count  <= '0;
    end else begin
      state      <= state_n;
      g_prev     <= g_prev_n;
      binary_out <= binary_n;
      valid      <= valid_n;
      hold       <= hold_n;
      step_up    <= step_up_n;
      step_down  <= step_down_n;
      step_err   <= step_err_n;
      err_count  <= err_count_n;
    end
  end

  // Next-state, classification and error-counter logic.
  always_comb begin
    state_n     = state;
    g_prev_n    = g_prev;
    binary_n    = binary_out;
    valid_n     = 1'b0;
    hold_n      = 1'b0;
    step_up_n   = 1'b0;
    step_down_n = 1'b0;
    step_err_n  = 1'b0;

    unique case (state)
      IDLE: begin
        if (enable) state_n = PRIME;
      end
      PRIME: begin
        // Seed the reference sample without classifying it, so nothing is
        // reported across a disabled gap.
        g_prev_n = g_s;
        binary_n = bin_s;
        if (enable) begin
          valid_n = 1'b1;
          state_n = TRACK;
        end else begin
          state_n = IDLE;
        end
      end
      TRACK: begin
        if (enable) begin
          g_prev_n = g_s;
          binary_n = bin_s;
          valid_n  = 1'b1;
          if (delta == '0)                 hold_n      = 1'b1;
          else if (delta == WIDTH'(1))     step_up_n   = 1'b1;
          else if (delta == '1)            step_down_n = 1'b1;
          else                             step_err_n  = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    // Clear wins over a coincident increment; saturate at all-ones.
    err_count_n = err_count;
    if (clr_err) begin
      err_count_n = '0;
    end else if (step_err_n && (err_count != '1)) begin
      err_count_n = err_count + ERR_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_gray_sync_decoder.sv
// tb_gray_sync_decoder
// Directed-vector bench for gray_sync_decoder (default parameters).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_gray_sync_decoder;

  logic       clk;
  logic       rst;
  logic [3:0] gray_in;
  logic       enable;
  logic       clr_err;
  logic [3:0] binary_out;
  logic       valid;
  logic       step_up;
  logic       step_down;
  logic       hold;
  logic       step_err;
  logic [7:0] err_count;

  int checks = 0;
  int errors = 0;

  // Flag vector packed as {hold, step_up, step_down, step_err}.
  logic [3:0] flags;
  assign flags = {hold, step_up, step_down, step_err};

  gray_sync_decoder #(
    .WIDTH      (4),
    .SYNC_STAGES(2),
    .ERR_CNT_W  (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .gray_in   (gray_in),
    .enable    (enable),
    .clr_err   (clr_err),
    .binary_out(binary_out),
    .valid     (valid),
    .step_up   (step_up),
    .step_down (step_down),
    .hold      (hold),
    .step_err  (step_err),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a new Gray value and wait out the synchroniser plus output register.
  task automatic apply(input logic [3:0] g);
    gray_in = g;
    tick();
    tick();
    tick();
  endtask

  initial begin
    rst     = 1'b1;
    gray_in = 4'b1111;
    enable  = 1'b1;
    clr_err = 1'b0;

    // 1. reset held two cycles
    tick();
    check("rst1_out",   {valid, flags, binary_out}, 32'h0);
    check("rst1_err",   err_count, 32'h0);
    tick();
    check("rst2_out",   {valid, flags, binary_out}, 32'h0);
    rst = 1'b0;
    tick();                                   // IDLE -> PRIME
    check("prime_entry_valid", valid, 32'h0);
    tick();                                   // PRIME actions
    check("prime_valid", valid, 32'h1);
    check("prime_flags", flags, 32'h0);

    // drop out to IDLE and settle 0011
    enable  = 1'b0;
    gray_in = 4'b0011;
    tick();
    check("idle_valid", valid, 32'h0);
    tick();
    tick();

    // 2. stable 0011 -> binary 2, then holds
    enable = 1'b1;
    tick();                                   // -> PRIME
    tick();                                   // PRIME
    check("p2_bin",   binary_out, 32'd2);
    check("p2_valid", valid, 32'h1);
    check("p2_flags", flags, 32'h0);
    tick();
    check("hold1", flags, 32'b1000);
    tick();
    check("hold2", flags, 32'b1000);

    // 3. 0011 -> 0010 -> 0110, one change per cycle from edge k
    gray_in = 4'b0010;                        // after edge k
    tick();                                   // k+1
    gray_in = 4'b0110;
    tick();                                   // k+2
    check("s3_k2_hold", flags, 32'b1000);
    tick();                                   // k+3
    check("s3_k3_bin", binary_out, 32'd3);
    check("s3_k3_up",  flags, 32'b0100);
    tick();                                   // k+4
    check("s3_k4_bin", binary_out, 32'd4);
    check("s3_k4_up",  flags, 32'b0100);

    // 4. wrap-around (4 -> 15 is an illegal jump on the way)
    apply(4'b1000);
    check("to15_bin", binary_out, 32'd15);
    check("to15_err", flags, 32'b0001);
    check("to15_cnt", err_count, 32'd1);
    apply(4'b0000);
    check("wrap_up_bin",  binary_out, 32'd0);
    check("wrap_up_flag", flags, 32'b0100);
    apply(4'b1000);
    check("wrap_dn_bin",  binary_out, 32'd15);
    check("wrap_dn_flag", flags, 32'b0010);
    apply(4'b0000);
    check("wrap_up2_flag", flags, 32'b0100);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("clr_cnt", err_count, 32'd0);
    check("clr_hold", flags, 32'b1000);

    // 5. illegal single-bit flip 0 -> 7, then saturation
    apply(4'b0100);
    check("jump_bin",  binary_out, 32'd7);
    check("jump_flag", flags, 32'b0001);
    check("jump_cnt",  err_count, 32'd1);
    for (int i = 0; i < 300; i++) begin
      gray_in = gray_in ^ 4'b0100;
      tick();
    end
    tick();
    tick();
    tick();
    check("sat_cnt",  err_count, 32'd255);
    check("sat_bin",  binary_out, 32'd7);
    check("sat_hold", flags, 32'b1000);
    gray_in = 4'b0000;
    tick();
    tick();
    clr_err = 1'b1;                           // coincides with the step_err edge
    tick();
    clr_err = 1'b0;
    check("clr_jump_flag", flags, 32'b0001);
    check("clr_jump_cnt",  err_count, 32'd0);

    // 6. reset mid-TRACK
    apply(4'b1101);
    check("at9_bin", binary_out, 32'd9);
    check("at9_cnt", err_count, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_bin",   binary_out, 32'd0);
    check("mid_rst_valid", valid, 32'h0);
    check("mid_rst_cnt",   err_count, 32'd0);
    tick();                                   // IDLE -> PRIME
    check("re_idle_valid", valid, 32'h0);
    tick();                                   // PRIME
    check("re_prime_valid", valid, 32'h1);
    check("re_prime_flags", flags, 32'h0);
    tick();                                   // TRACK: 0 -> 9
    check("re_track_bin",  binary_out, 32'd9);
    check("re_track_flag", flags, 32'b0001);
    tick();
    check("re_track_hold", flags, 32'b1000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
